// File: rtl/simd_job_ctrl.sv
// SIMD job controller: polls a BRAM mailbox for a new doorbell sequence,
// launches the SIMD core with the posted configuration, times the run and
// writes busy / done status words back to the mailbox.
module simd_job_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [1:0]  bram_addr,
  input  logic [63:0] bram_dout,
  output logic [63:0] bram_din,
  output logic        bram_wen,
  output logic [31:0] core_cfg,
  output logic        core_start,
  input  logic        core_done
);

  typedef enum logic [2:0] {
    StPoll,
    StRdwait,
    StCheck,
    StWrbusy,
    StStart,
    StRun,
    StWrdone
  } state_e;

  // Last RUN count value before the job is declared timed out.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] last_seq_q, last_seq_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] cfg_q, cfg_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic        err_q, err_d;
  logic [31:0] core_cfg_q, core_cfg_d;

  logic [31:0] dbell_seq;
  assign dbell_seq = bram_dout[63:32];

  // State and job registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StPoll;
      last_seq_q  <= '0;
      seq_q       <= '0;
      cfg_q       <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
      core_cfg_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_seq_q  <= last_seq_d;
      seq_q       <= seq_d;
      cfg_q       <= cfg_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
      core_cfg_q  <= core_cfg_d;
    end
  end

  // Next-state logic and job bookkeeping.
  always_comb begin
    state_d     = state_q;
    last_seq_d  = last_seq_q;
    seq_d       = seq_q;
    cfg_d       = cfg_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    core_cfg_d  = core_cfg_q;
    unique case (state_q)
      StPoll:   state_d = StRdwait;
      StRdwait: state_d = StCheck;
      StCheck: begin
        // Sequence 0 means "no job"; an unchanged sequence was already served.
        if (dbell_seq != last_seq_q && dbell_seq != 32'h0) begin
          seq_d      = dbell_seq;
          cfg_d      = bram_dout[31:0];
          last_seq_d = dbell_seq;
          state_d    = StWrbusy;
        end else begin
          state_d = StPoll;
        end
      end
      StWrbusy: begin
        // Load core_cfg now so it is already valid during the start pulse.
        core_cfg_d = cfg_q;
        state_d    = StStart;
      end
      StStart: begin
        cycle_cnt_d = '0;
        state_d     = StRun;
      end
      StRun: begin
        if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
        // Done takes priority over a simultaneous timeout.
        if (core_done) begin
          err_d   = 1'b0;
          state_d = StWrdone;
        end else if (cycle_cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StWrdone;
        end
      end
      StWrdone: state_d = StPoll;
      default:  state_d = StPoll;
    endcase
  end

  // Mailbox and core outputs decoded from the current state.
  always_comb begin
    bram_addr  = 2'd0;
    bram_wen   = 1'b0;
    bram_din   = '0;
    core_start = 1'b0;
    core_cfg   = core_cfg_q;
    if (state_q == StWrbusy) begin
      bram_addr = 2'd1;
      bram_wen  = 1'b1;
      bram_din  = {seq_q, 16'h0, 13'h0, 3'b001};
    end else if (state_q == StWrdone) begin
      bram_addr = 2'd1;
      bram_wen  = 1'b1;
      bram_din  = {seq_q, cycle_cnt_q, 13'h0, err_q, 1'b1, 1'b0};
    end else if (state_q == StStart) begin
      core_start = 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_job_ctrl.sv
// Self-checking bench for simd_job_ctrl: BRAM mailbox model plus a
// job-level reference that predicts status words and event timing.
module tb_simd_job_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rstn;
  logic [1:0]  bram_addr;
  logic [63:0] bram_dout;
  logic [63:0] bram_din;
  logic        bram_wen;
  logic [31:0] core_cfg;
  logic        core_start;
  logic        core_done;

  logic [63:0] cmd;
  logic [63:0] status_mem;

  int checks;
  int errors;
  int starts;
  int writes;
  int exp_starts;
  int exp_writes;

  simd_job_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .bram_din  (bram_din),
    .bram_wen  (bram_wen),
    .core_cfg  (core_cfg),
    .core_start(core_start),
    .core_done (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mailbox: word 0 is the command posted by the host, word 1 the status.
  always @(posedge clk) begin
    bram_dout <= (bram_addr == 2'd0) ? cmd : status_mem;
    if (bram_wen && bram_addr == 2'd1) status_mem <= bram_din;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Event counters and the address rule: writes go to status, all else reads cmd.
  always @(negedge clk) begin
    if (rstn) begin
      if (bram_wen) writes++;
      if (core_start) starts++;
      check("addr_rule", {62'h0, bram_addr}, bram_wen ? 64'd1 : 64'd0);
    end
  end

  task automatic idle(input int n);
    int w, s;
    w = 0;
    s = 0;
    repeat (n) begin
      @(negedge clk);
      if (bram_wen) w++;
      if (core_start) s++;
      core_done = 1'($urandom_range(0, 1));
    end
    core_done = 1'b0;
    check("idle_wen", w, 0);
    check("idle_start", s, 0);
  endtask

  // Post a doorbell and follow one job. Completion is predicted as
  // min(d, TIMEOUT) RUN cycles, erroring only when d exceeds TIMEOUT.
  task automatic run_job(input logic [31:0] seq, input logic [31:0] cfg, input int d,
                         input bit chg, input logic [63:0] new_cmd, input bit do_reset);
    bit seen;
    int e;
    cmd = {seq, cfg};
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bram_wen) seen = 1'b1;
      else core_done = 1'($urandom_range(0, 1));
    end
    core_done = 1'b0;
    if (!seen) begin
      check("busy_seen", 0, 1);
      return;
    end
    check("busy_word", bram_din, {seq, 32'h1});
    exp_writes++;
    @(negedge clk);
    check("start_pulse", core_start, 1);
    check("start_cfg", core_cfg, cfg);
    exp_starts++;
    e = (d <= TIMEOUT) ? d : TIMEOUT;
    seen = 1'b0;
    for (int k = 1; k <= TIMEOUT + 8 && !seen; k++) begin
      @(negedge clk);
      if (bram_wen) begin
        seen = 1'b1;
        exp_writes++;
        check("done_when", k, e + 1);
        check("done_word", bram_din, {seq, 16'(e), 13'h0, 1'(d > TIMEOUT), 2'b10});
      end
      if (core_start) check("extra_start", 1, 0);
      check("cfg_hold", core_cfg, cfg);
      core_done = (k == d);
      if (chg && k == 2) cmd = new_cmd;
      if (do_reset && k == 3) begin
        core_done = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("rst_cfg", core_cfg, 0);
        check("rst_wen", bram_wen, 0);
        rstn = 1'b1;
        return;
      end
    end
    core_done = 1'b0;
    if (!seen) check("done_seen", 0, 1);
  endtask

  initial begin
    logic [31:0] seq;
    logic [31:0] nseq;
    logic [31:0] cfg;
    logic [31:0] ncfg;
    int d;
    bit chg;
    checks = 0;
    errors = 0;
    starts = 0;
    writes = 0;
    exp_starts = 0;
    exp_writes = 0;
    status_mem = '0;
    core_done = 1'b0;
    rstn = 1'b0;
    cmd = {32'h0, $urandom};
    repeat (3) @(negedge clk);
    check("rst_wen0", bram_wen, 0);
    check("rst_start0", core_start, 0);
    check("rst_addr0", bram_addr, 0);
    check("rst_din0", bram_din, 0);
    check("rst_cfg0", core_cfg, 0);
    rstn = 1'b1;
    // Doorbell 0 must never launch.
    idle(30);

    run_job(32'h1, 32'hCAFE, 5, 1'b0, 64'h0, 1'b0);
    idle(200);
    // Timeout: done never comes.
    run_job(32'h2, $urandom, TIMEOUT + 100, 1'b0, 64'h0, 1'b0);
    // Done on the last allowed cycle wins over the timeout.
    run_job(32'h3, $urandom, TIMEOUT, 1'b0, 64'h0, 1'b0);
    // Doorbell changes mid-run: job 4 finishes, then job 5 launches separately.
    ncfg = $urandom;
    run_job(32'h4, $urandom, 6, 1'b1, {32'h5, ncfg}, 1'b0);
    run_job(32'h5, ncfg, 3, 1'b0, 64'h0, 1'b0);
    // Reset mid-run, then relaunch of the same doorbell.
    cfg = $urandom;
    run_job(32'h7, cfg, 10, 1'b0, 64'h0, 1'b1);
    run_job(32'h7, cfg, 4, 1'b0, 64'h0, 1'b0);

    seq = 32'h7;
    for (int j = 0; j < 30; j++) begin
      seq = seq + 32'($urandom_range(1, 100));
      cfg = $urandom;
      d = $urandom_range(1, TIMEOUT + 4);
      chg = ($urandom_range(0, 3) == 0) && (d > 2);
      if (chg) begin
        nseq = seq + 32'($urandom_range(1, 100));
        ncfg = $urandom;
        run_job(seq, cfg, d, 1'b1, {nseq, ncfg}, 1'b0);
        seq = nseq;
        cfg = ncfg;
        d = $urandom_range(1, TIMEOUT + 4);
        run_job(seq, cfg, d, 1'b0, 64'h0, 1'b0);
      end else begin
        run_job(seq, cfg, d, 1'b0, 64'h0, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(5, 20));
    end

    idle(20);
    check("start_count", starts, exp_starts);
    check("write_count", writes, exp_writes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_job_ctrl.md
SIMD_JOB_CTRL -- requirements
Module: simd_job_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum RUN cycles before the job is aborted as timed out (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock for all state.
REQ-003 The block SHALL have port rstn, input, 1, the synchronous active-low reset.
REQ-004 The block SHALL have port bram_addr, output, 2, the mailbox word address (0 = command word, 1 = status word).
REQ-005 The block SHALL have port bram_dout, input, 64, the mailbox read data, valid one cycle after bram_addr is presented.
REQ-006 The block SHALL have port bram_din, output, 64, the mailbox write data.
REQ-007 The block SHALL have port bram_wen, output, 1, the mailbox write enable; bram_din is written to bram_addr in the cycle it is 1.
REQ-008 The block SHALL have port core_cfg, output, 32, the job configuration presented to the SIMD core.
REQ-009 The block SHALL have port core_start, output, 1, a single-cycle launch pulse to the SIMD core.
REQ-010 The block SHALL have port core_done, input, 1, the job-complete pulse or level from the SIMD core.

Function
REQ-011 Command word layout SHALL be [63:32] = doorbell sequence number and [31:0] = configuration.
REQ-012 Status word layout SHALL be: [63:32] = echoed sequence, [31:16] = RUN cycle count, [2] = timeout error, [1] = done, [0] = busy, and all other bits 0.
REQ-013 The FSM SHALL have the states POLL, RDWAIT, CHECK, WRBUSY, START, RUN and WRDONE.
REQ-014 POLL SHALL drive bram_addr=0 and bram_wen=0, then go to RDWAIT.
REQ-015 RDWAIT SHALL drive bram_addr=0 for one cycle, then go to CHECK.
REQ-016 In CHECK, if bram_dout[63:32] != last_seq and != 0, the block SHALL latch seq and cfg, set last_seq=seq, and go to WRBUSY; otherwise it SHALL go to POLL.
REQ-017 WRBUSY SHALL, for one cycle, drive bram_addr=1, bram_wen=1 and a status word of {seq, 16'h0, 3'b001}, then go to START.
REQ-018 START SHALL drive core_cfg = the latched cfg and core_start=1 for exactly one cycle, clear cycle_cnt, then go to RUN.
REQ-019 In RUN, cycle_cnt SHALL increment by 1 each cycle and saturate at 16'hFFFF.
REQ-020 In RUN, if core_done=1, the block SHALL go to WRDONE with err=0.
REQ-021 In RUN, otherwise, if cycle_cnt == TIMEOUT-1, the block SHALL go to WRDONE with err=1.
REQ-022 WRDONE SHALL, for one cycle, write the status word {seq, cycle_cnt, err, 1'b1, 1'b0} to address 1, then go to POLL.
REQ-023 core_done=1 and the timeout SHALL resolve as done (err=0) when they occur in the same cycle.
REQ-024 core_done SHALL be ignored in every state except RUN.
REQ-025 A doorbell change while in WRBUSY, START, RUN or WRDONE SHALL NOT be sampled; it is picked up at the next CHECK.
REQ-026 core_cfg SHALL hold the latched cfg from START until the next launch.
REQ-027 bram_wen SHALL be 1 only in WRBUSY and WRDONE.
REQ-028 bram_addr SHALL be 0 in all other states.
REQ-029 Back-to-back jobs SHALL each require a full POLL->RDWAIT->CHECK pass; minimum launch-to-launch spacing is cycle_cnt+6 cycles.

Reset
REQ-030 While rstn=0 at a rising clk edge, the FSM SHALL return to POLL, including from mid-job.
REQ-031 Reset SHALL clear last_seq, seq, cfg, cycle_cnt, err, core_cfg, core_start, bram_wen, bram_din and bram_addr to 0.
REQ-032 After reset, doorbell value 0 SHALL never launch a job.
REQ-033 A job interrupted by reset SHALL NOT receive a WRDONE write.
REQ-034 If its doorbell still differs from 0 after reset, an interrupted job SHALL be relaunched.

Verification
REQ-035 Normal job: cmd={32'h1,32'hCAFE}, core_done 5 cycles after core_start -> status {1,0,001} written, one core_start pulse with core_cfg=CAFE, then status {1,16'd5,3'b010}.
REQ-036 No new doorbell: cmd seq left at 1 after a completed job -> no further core_start and no writes for 200 cycles.
REQ-037 Timeout: TIMEOUT=16 and core_done never asserted -> status {seq,16'd16,3'b110} written and the FSM returns to POLL.
REQ-038 Done/timeout collision: core_done asserted on the cycle cycle_cnt==TIMEOUT-1 -> err=0 and done=1.
REQ-039 Reset mid-RUN: rstn low for 1 cycle during RUN with seq=7 -> no WRDONE for the old run, and a relaunch with seq 7 yielding status busy then done.
REQ-040 Doorbell change during RUN: seq 2->3 while job 2 runs -> job 2 completes with echo 2, followed by a separate launch and echo 3.
